// File: rtl/conv_output_collector_pkg.sv
// rtl/conv_output_collector_pkg.sv - shared types and output-map geometry helpers
package conv_output_collector_pkg;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_DRAIN   = 1'b1
    } state_t;

    // Convolver, collector and pooling stages derive their map size from these.
    function automatic int calc_out_w(input int w, input int k, input int st);
        return (w - k) / st + 1;
    endfunction

    function automatic int calc_out_n(input int w, input int k, input int st);
        return calc_out_w(w, k, st) * calc_out_w(w, k, st);
    endfunction

endpackage

// File: rtl/conv_output_collector_fmap_buffer.sv
// rtl/conv_output_collector_fmap_buffer.sv - feature-map store, sync write, async read
module conv_output_collector_fmap_buffer #(
    parameter int DW    = 16,
    parameter int DEPTH = 676,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/conv_output_collector.sv
// rtl/conv_output_collector.sv - captures one convolver feature map, then drains it as a stream
module conv_output_collector
    import conv_output_collector_pkg::*;
#(
    parameter int dataWidth = 16,
    parameter int W         = 28,
    parameter int K         = 3,
    parameter int s         = 1,
    parameter int RELU      = 1
) (
    input  logic                 clk,
    input  logic                 global_rst,
    input  logic                 ce,
    input  logic [dataWidth-1:0] conv_op,
    input  logic                 valid_conv,
    input  logic                 end_conv,
    output logic [dataWidth-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overflow,
    output logic                 short_frame
);

    localparam int OUT_W = calc_out_w(W, K, s);
    localparam int OUT_N = calc_out_n(W, K, s);
    localparam int CW    = $clog2(OUT_N + 1);
    localparam int AW    = (OUT_N > 1) ? $clog2(OUT_N) : 1;
    localparam logic [CW-1:0] OUT_N_C = CW'(OUT_N);

    state_t              state, state_nx;
    logic [CW-1:0]       wr_cnt, wr_nx;
    logic [CW-1:0]       rd_addr, rd_nx;
    logic [CW-1:0]       length, len_nx;
    logic                short_nx, ovf_nx, done_nx;
    logic                mem_we;
    logic [dataWidth-1:0] mem_wdata, mem_rdata;

    assign mem_wdata = ((RELU != 0) && conv_op[dataWidth-1]) ? '0 : conv_op;

    conv_output_collector_fmap_buffer #(
        .DW    (dataWidth),
        .DEPTH (OUT_N),
        .AW    (AW)
    ) u_fmap_buffer (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_cnt[AW-1:0]),
        .wdata (mem_wdata),
        .raddr (rd_addr[AW-1:0]),
        .rdata (mem_rdata)
    );

    assign busy      = (state == ST_DRAIN);
    assign out_valid = busy;
    assign out_data  = busy ? mem_rdata : '0;
    assign out_last  = busy && (rd_addr == length - 1'b1);

    always_ff @(posedge clk or negedge global_rst) begin
        if (!global_rst) begin
            state       <= ST_COLLECT;
            wr_cnt      <= '0;
            rd_addr     <= '0;
            length      <= '0;
            short_frame <= 1'b0;
            overflow    <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nx;
            wr_cnt      <= wr_nx;
            rd_addr     <= rd_nx;
            length      <= len_nx;
            short_frame <= short_nx;
            overflow    <= ovf_nx;
            frame_done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wr_nx    = wr_cnt;
        rd_nx    = rd_addr;
        len_nx   = length;
        short_nx = short_frame;
        ovf_nx   = overflow;
        done_nx  = 1'b0;
        mem_we   = 1'b0;
        if (state == ST_COLLECT) begin
            if (ce && valid_conv) begin
                mem_we = 1'b1;
                wr_nx  = wr_cnt + 1'b1;
                if (wr_nx == OUT_N_C) begin
                    state_nx = ST_DRAIN;
                    len_nx   = OUT_N_C;
                end
            end else if (ce && end_conv && (wr_cnt != '0)) begin
                // Truncated frame: drain whatever was captured.
                short_nx = 1'b1;
                state_nx = ST_DRAIN;
                len_nx   = wr_cnt;
            end
        end else begin
            if (ce && valid_conv) begin
                ovf_nx = 1'b1;
            end
            if (out_ready) begin
                rd_nx = rd_addr + 1'b1;
                if (out_last) begin
                    state_nx = ST_COLLECT;
                    wr_nx    = '0;
                    rd_nx    = '0;
                    done_nx  = 1'b1;
                end
            end
        end
    end

endmodule
